// File: rtl/alu_seq_ctrl_pkg.sv
// Shared definitions for the ALU sequencer: opcode constants, FSM state
// encoding and small opcode classification helpers.
package alu_seq_ctrl_pkg;

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b0001;
  localparam logic [3:0] OP_PASS = 4'b0010;
  localparam logic [3:0] OP_NAND = 4'b0011;
  localparam logic [3:0] OP_NOR  = 4'b0100;
  localparam logic [3:0] OP_XNOR = 4'b0101;
  localparam logic [3:0] OP_NOT  = 4'b0110;
  localparam logic [3:0] OP_AND  = 4'b0111;
  localparam logic [3:0] OP_OR   = 4'b1000;
  localparam logic [3:0] OP_XOR  = 4'b1001;
  localparam logic [3:0] OP_LSR  = 4'b1010;
  localparam logic [3:0] OP_ASR  = 4'b1011;
  localparam logic [3:0] OP_ROR  = 4'b1100;
  localparam logic [3:0] OP_LSL  = 4'b1101;
  localparam logic [3:0] OP_ASL  = 4'b1110;
  localparam logic [3:0] OP_ROL  = 4'b1111;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LO    = 3'd1,
    ST_HI    = 3'd2,
    ST_SHIFT = 3'd3,
    ST_RESP  = 3'd4
  } state_e;

  // Opcodes 1010..1111 are the single-bit shift/rotate steps.
  function automatic logic is_shift(input logic [3:0] op);
    return (op[3:1] >= 3'b101);
  endfunction

  function automatic logic is_addsub(input logic [3:0] op);
    return (op == OP_ADD) || (op == OP_SUB);
  endfunction

endpackage

// File: rtl/alu_seq_ctrl.sv
// Sequencer in front of an external 16-bit combinational ALU: chains two
// passes for 32-bit add/sub and repeats single-bit shifts up to 2**SHW-1 times.
module alu_seq_ctrl
  import alu_seq_ctrl_pkg::*;
#(
  parameter int W   = 16,
  parameter int SHW = 4
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           req_valid,
  output logic           req_ready,
  input  logic [3:0]     req_op,
  input  logic [2*W-1:0] req_a,
  input  logic [2*W-1:0] req_b,
  input  logic           req_cin,
  input  logic           req_wide,
  input  logic [SHW-1:0] req_shamt,
  output logic           rsp_valid,
  input  logic           rsp_ready,
  output logic [2*W-1:0] rsp_data,
  output logic           rsp_carry,
  output logic [W-1:0]   alu_a,
  output logic [W-1:0]   alu_b,
  output logic           alu_cin,
  output logic [3:0]     alu_op,
  input  logic [W-1:0]   alu_c,
  input  logic           alu_cout,
  output logic           busy
);

  state_e         state_q, state_d;
  logic [W-1:0]   alu_a_q, alu_a_d;
  logic [W-1:0]   alu_b_q, alu_b_d;
  logic           alu_cin_q, alu_cin_d;
  logic [3:0]     alu_op_q, alu_op_d;
  logic [W-1:0]   a_hi_q, a_hi_d;
  logic [W-1:0]   b_hi_q, b_hi_d;
  logic [W-1:0]   low_q, low_d;
  logic           wide_q, wide_d;
  logic [SHW-1:0] cnt_q, cnt_d;
  logic [2*W-1:0] rsp_data_q, rsp_data_d;
  logic           rsp_carry_q, rsp_carry_d;

  always_comb begin
    state_d     = state_q;
    alu_a_d     = alu_a_q;
    alu_b_d     = alu_b_q;
    alu_cin_d   = alu_cin_q;
    alu_op_d    = alu_op_q;
    a_hi_d      = a_hi_q;
    b_hi_d      = b_hi_q;
    low_d       = low_q;
    wide_d      = wide_q;
    cnt_d       = cnt_q;
    rsp_data_d  = rsp_data_q;
    rsp_carry_d = rsp_carry_q;

    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          alu_a_d   = req_a[W-1:0];
          alu_b_d   = req_b[W-1:0];
          alu_cin_d = req_cin;
          alu_op_d  = req_op;
          a_hi_d    = req_a[2*W-1:W];
          b_hi_d    = req_b[2*W-1:W];
          wide_d    = req_wide;
          cnt_d     = req_shamt;
          if (is_shift(req_op)) begin
            // A zero-length shift answers with operand A without touching the ALU.
            if (req_shamt == '0) begin
              rsp_data_d  = {{W{1'b0}}, req_a[W-1:0]};
              rsp_carry_d = 1'b0;
              state_d     = ST_RESP;
            end else begin
              state_d = ST_SHIFT;
            end
          end else begin
            state_d = ST_LO;
          end
        end
      end

      ST_LO: begin
        if (wide_q && is_addsub(alu_op_q)) begin
          low_d     = alu_c;
          alu_a_d   = a_hi_q;
          alu_b_d   = b_hi_q;
          alu_cin_d = alu_cout;
          state_d   = ST_HI;
        end else begin
          rsp_data_d  = {{W{1'b0}}, alu_c};
          rsp_carry_d = is_addsub(alu_op_q) ? alu_cout : 1'b0;
          state_d     = ST_RESP;
        end
      end

      ST_HI: begin
        rsp_data_d  = {alu_c, low_q};
        rsp_carry_d = alu_cout;
        state_d     = ST_RESP;
      end

      ST_SHIFT: begin
        alu_a_d = alu_c;
        cnt_d   = cnt_q - SHW'(1);
        if (cnt_q == SHW'(1)) begin
          rsp_data_d  = {{W{1'b0}}, alu_c};
          rsp_carry_d = 1'b0;
          state_d     = ST_RESP;
        end
      end

      ST_RESP: begin
        if (rsp_ready) begin
          state_d = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      alu_cin_q   <= 1'b0;
      alu_op_q    <= '0;
      a_hi_q      <= '0;
      b_hi_q      <= '0;
      low_q       <= '0;
      wide_q      <= 1'b0;
      cnt_q       <= '0;
      rsp_data_q  <= '0;
      rsp_carry_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      alu_a_q     <= alu_a_d;
      alu_b_q     <= alu_b_d;
      alu_cin_q   <= alu_cin_d;
      alu_op_q    <= alu_op_d;
      a_hi_q      <= a_hi_d;
      b_hi_q      <= b_hi_d;
      low_q       <= low_d;
      wide_q      <= wide_d;
      cnt_q       <= cnt_d;
      rsp_data_q  <= rsp_data_d;
      rsp_carry_q <= rsp_carry_d;
    end
  end

  assign req_ready = (state_q == ST_IDLE);
  assign busy      = (state_q != ST_IDLE);
  assign rsp_valid = (state_q == ST_RESP);
  assign rsp_data  = rsp_data_q;
  assign rsp_carry = rsp_carry_q;
  assign alu_a     = alu_a_q;
  assign alu_b     = alu_b_q;
  assign alu_cin   = alu_cin_q;
  assign alu_op    = alu_op_q;

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Directed-vector bench for alu_seq_ctrl with a behavioural model of the
// external 16-bit ALU wired to the sequencer's ALU port.
module tb_alu_seq_ctrl;
  import alu_seq_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [3:0]  req_op;
  logic [31:0] req_a;
  logic [31:0] req_b;
  logic        req_cin;
  logic        req_wide;
  logic [3:0]  req_shamt;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_data;
  logic        rsp_carry;
  logic [15:0] alu_a;
  logic [15:0] alu_b;
  logic        alu_cin;
  logic [3:0]  alu_op;
  logic [15:0] alu_c;
  logic        alu_cout;
  logic        busy;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  alu_seq_ctrl #(.W(16), .SHW(4)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_a(req_a), .req_b(req_b), .req_cin(req_cin), .req_wide(req_wide),
    .req_shamt(req_shamt),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_carry(rsp_carry),
    .alu_a(alu_a), .alu_b(alu_b), .alu_cin(alu_cin), .alu_op(alu_op),
    .alu_c(alu_c), .alu_cout(alu_cout), .busy(busy)
  );

  // External ALU: returns {cout, c}; subtract reports a borrow in cout.
  function automatic logic [16:0] alu_model(input logic [3:0] op, input logic [15:0] a,
                                            input logic [15:0] b, input logic cin);
    logic [16:0] r;
    r = '0;
    case (op)
      OP_ADD:  r = {1'b0, a} + {1'b0, b} + {16'd0, cin};
      OP_SUB:  r = {1'b0, a} - {1'b0, b} - {16'd0, cin};
      OP_PASS: r = {1'b0, a};
      OP_NAND: r = {1'b0, ~(a & b)};
      OP_NOR:  r = {1'b0, ~(a | b)};
      OP_XNOR: r = {1'b0, ~(a ^ b)};
      OP_NOT:  r = {1'b0, ~a};
      OP_AND:  r = {1'b0, a & b};
      OP_OR:   r = {1'b0, a | b};
      OP_XOR:  r = {1'b0, a ^ b};
      OP_LSR:  r = {a[0], 1'b0, a[15:1]};
      OP_ASR:  r = {a[0], a[15], a[15:1]};
      OP_ROR:  r = {a[0], a[0], a[15:1]};
      OP_LSL:  r = {a[15], a[14:0], 1'b0};
      OP_ASL:  r = {a[15], a[14:0], 1'b0};
      OP_ROL:  r = {a[15], a[14:0], a[15]};
      default: r = '0;
    endcase
    return r;
  endfunction

  always_comb {alu_cout, alu_c} = alu_model(alu_op, alu_a, alu_b, alu_cin);

  // Presents one request, then waits (bounded) for rsp_valid; lat counts edges from acceptance.
  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic cin, input logic wide, input logic [3:0] shamt,
                       output int lat);
    @(negedge clk);
    req_op = op; req_a = a; req_b = b; req_cin = cin; req_wide = wide; req_shamt = shamt;
    req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 1;
    while (!rsp_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic release_rsp;
    @(negedge clk);
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset;
    @(negedge clk); reset = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    vectors++;
    if (req_ready !== 1'b1 || busy !== 1'b0 || rsp_valid !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL reset_hs: ready=%b busy=%b valid=%b, required 1 0 0", req_ready, busy, rsp_valid);
    end
    vectors++;
    if ({alu_a, alu_b, alu_cin, alu_op} !== 37'd0 || rsp_data !== 32'd0 || rsp_carry !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL reset_regs: alu_a=%h alu_b=%h cin=%b op=%h data=%h carry=%b, required all 0",
               alu_a, alu_b, alu_cin, alu_op, rsp_data, rsp_carry);
    end
    @(negedge clk); reset = 1'b0;
  endtask

  task automatic test_narrow;
    int lat;
    issue(OP_ADD, 32'h0000_0001, 32'h0000_FFFF, 1'b0, 1'b0, 4'd0, lat);
    vectors++;
    if (rsp_data !== 32'h0000_0000 || rsp_carry !== 1'b1 || lat !== 2) begin
      miscompares++;
      $display("[TB] FAIL narrow_add: data=%h carry=%b lat=%0d, required 00000000 1 2", rsp_data, rsp_carry, lat);
    end
    release_rsp();
    vectors++;
    if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL narrow_add_release: ready=%b valid=%b, required 1 0", req_ready, rsp_valid);
    end
    issue(OP_SUB, 32'hABCD_0005, 32'h1234_0007, 1'b0, 1'b0, 4'd0, lat);
    vectors++;
    if (rsp_data !== 32'h0000_FFFE || rsp_carry !== 1'b1 || lat !== 2) begin
      miscompares++;
      $display("[TB] FAIL narrow_sub: data=%h carry=%b lat=%0d, required 0000fffe 1 2", rsp_data, rsp_carry, lat);
    end
    release_rsp();
    issue(OP_XOR, 32'h0000_00FF, 32'h0000_0F0F, 1'b1, 1'b1, 4'd7, lat);
    vectors++;
    if (rsp_data !== 32'h0000_0FF0 || rsp_carry !== 1'b0 || lat !== 2) begin
      miscompares++;
      $display("[TB] FAIL narrow_xor: data=%h carry=%b lat=%0d, required 00000ff0 0 2", rsp_data, rsp_carry, lat);
    end
    release_rsp();
  endtask

  task automatic test_wide_add;
    @(negedge clk);
    req_op = OP_ADD; req_a = 32'h0000_FFFF; req_b = 32'h0000_0001;
    req_cin = 1'b0; req_wide = 1'b1; req_shamt = 4'd0; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    vectors++;
    if (alu_a !== 16'hFFFF || alu_b !== 16'h0001 || alu_cin !== 1'b0 || rsp_valid !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL wide_add_lo: a=%h b=%h cin=%b valid=%b, required ffff 0001 0 0", alu_a, alu_b, alu_cin, rsp_valid);
    end
    @(posedge clk); #1;
    vectors++;
    if (alu_a !== 16'h0000 || alu_b !== 16'h0000 || alu_cin !== 1'b1 || rsp_valid !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL wide_add_hi: a=%h b=%h cin=%b valid=%b, required 0000 0000 1 0", alu_a, alu_b, alu_cin, rsp_valid);
    end
    @(posedge clk); #1;
    vectors++;
    if (rsp_valid !== 1'b1 || rsp_data !== 32'h0001_0000 || rsp_carry !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL wide_add_rsp: valid=%b data=%h carry=%b, required 1 00010000 0", rsp_valid, rsp_data, rsp_carry);
    end
    release_rsp();
  endtask

  task automatic test_wide_sub;
    int lat;
    issue(OP_SUB, 32'h0000_0000, 32'h0000_0001, 1'b0, 1'b1, 4'd0, lat);
    vectors++;
    if (rsp_data !== 32'hFFFF_FFFF || rsp_carry !== 1'b1 || lat !== 3) begin
      miscompares++;
      $display("[TB] FAIL wide_sub_under: data=%h carry=%b lat=%0d, required ffffffff 1 3", rsp_data, rsp_carry, lat);
    end
    release_rsp();
    issue(OP_SUB, 32'h0001_0000, 32'h0000_0001, 1'b0, 1'b1, 4'd0, lat);
    vectors++;
    if (rsp_data !== 32'h0000_FFFF || rsp_carry !== 1'b0 || lat !== 3) begin
      miscompares++;
      $display("[TB] FAIL wide_sub_borrow: data=%h carry=%b lat=%0d, required 0000ffff 0 3", rsp_data, rsp_carry, lat);
    end
    release_rsp();
  endtask

  task automatic test_shift;
    int lat;
    issue(OP_ROL, 32'h0000_1234, 32'h0000_0000, 1'b0, 1'b0, 4'd4, lat);
    vectors++;
    if (rsp_data !== 32'h0000_2341 || rsp_carry !== 1'b0 || lat !== 5) begin
      miscompares++;
      $display("[TB] FAIL rol4: data=%h carry=%b lat=%0d, required 00002341 0 5", rsp_data, rsp_carry, lat);
    end
    release_rsp();
    issue(OP_ROL, 32'hFFFF_1234, 32'h0000_0000, 1'b0, 1'b0, 4'd0, lat);
    vectors++;
    if (rsp_data !== 32'h0000_1234 || rsp_carry !== 1'b0 || lat !== 1) begin
      miscompares++;
      $display("[TB] FAIL rol0: data=%h carry=%b lat=%0d, required 00001234 0 1", rsp_data, rsp_carry, lat);
    end
    vectors++;
    if (alu_a !== 16'h1234 || alu_op !== OP_ROL) begin
      miscompares++;
      $display("[TB] FAIL rol0_nostep: alu_a=%h alu_op=%h, required 1234 f", alu_a, alu_op);
    end
    release_rsp();
    issue(OP_ASR, 32'h0000_8000, 32'h0000_0000, 1'b0, 1'b0, 4'd15, lat);
    vectors++;
    if (rsp_data !== 32'h0000_FFFF || rsp_carry !== 1'b0 || lat !== 16) begin
      miscompares++;
      $display("[TB] FAIL asr15: data=%h carry=%b lat=%0d, required 0000ffff 0 16", rsp_data, rsp_carry, lat);
    end
    release_rsp();
  endtask

  task automatic test_back_to_back;
    int lat;
    logic [31:0] held;
    int bad;
    issue(OP_XOR, 32'h0000_00FF, 32'h0000_0F0F, 1'b0, 1'b0, 4'd0, lat);
    held = rsp_data;
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      if (rsp_valid !== 1'b1 || req_ready !== 1'b0 || rsp_data !== 32'h0000_0FF0) bad++;
    end
    vectors++;
    if (bad !== 0 || held !== 32'h0000_0FF0) begin
      miscompares++;
      $display("[TB] FAIL backpressure_hold: bad_cycles=%0d data=%h, required 0 00000ff0", bad, rsp_data);
    end
    @(negedge clk);
    rsp_ready = 1'b1;
    req_op = OP_LSR; req_a = 32'h0000_8000; req_b = 32'h0; req_cin = 1'b0;
    req_wide = 1'b0; req_shamt = 4'd3; req_valid = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    vectors++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b1 || busy !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL handshake_turn: valid=%b ready=%b busy=%b, required 0 1 0", rsp_valid, req_ready, busy);
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
    vectors++;
    if (busy !== 1'b1 || req_ready !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL b2b_accept: busy=%b ready=%b, required 1 0", busy, req_ready);
    end
    lat = 1;
    while (!rsp_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    vectors++;
    if (rsp_data !== 32'h0000_1000 || rsp_carry !== 1'b0 || lat !== 4) begin
      miscompares++;
      $display("[TB] FAIL b2b_lsr3: data=%h carry=%b lat=%0d, required 00001000 0 4", rsp_data, rsp_carry, lat);
    end
    release_rsp();
  endtask

  task automatic test_reset_mid;
    logic seen;
    @(negedge clk);
    req_op = OP_ROL; req_a = 32'h0000_1234; req_b = 32'h0000_5555; req_cin = 1'b1;
    req_wide = 1'b0; req_shamt = 4'd15; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #1;
    vectors++;
    if (busy !== 1'b0 || req_ready !== 1'b1 || rsp_valid !== 1'b0 ||
        {alu_a, alu_b, alu_cin, alu_op} !== 37'd0) begin
      miscompares++;
      $display("[TB] FAIL reset_mid: busy=%b ready=%b valid=%b a=%h b=%h cin=%b op=%h, required 0 1 0 and alu all 0",
               busy, req_ready, rsp_valid, alu_a, alu_b, alu_cin, alu_op);
    end
    @(negedge clk); reset = 1'b0;
    seen = 1'b0;
    rsp_ready = 1'b1;
    repeat (30) begin
      @(posedge clk); #1;
      if (rsp_valid) seen = 1'b1;
    end
    rsp_ready = 1'b0;
    vectors++;
    if (seen !== 1'b0 || req_ready !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL reset_mid_norsp: seen_valid=%b ready=%b, required 0 1", seen, req_ready);
    end
  endtask

  initial begin
    reset = 1'b1; req_valid = 1'b0; req_op = '0; req_a = '0; req_b = '0;
    req_cin = 1'b0; req_wide = 1'b0; req_shamt = '0; rsp_ready = 1'b0;
    test_reset();
    test_narrow();
    test_wide_add();
    test_wide_sub();
    test_shift();
    test_back_to_back();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL global_timeout: simulation did not complete, required completion");
    $fatal(1, "[TB] timeout");
  end

endmodule

// File: doc/alu_seq_ctrl.md
Name: alu_seq_ctrl

Overview:
- Initiator-side sequencer that drives the 16-bit combinational ALU (A, B, Cin, OP in; C, Cout out) and owns its operand and opcode lines.
- Accepts operation requests over a valid/ready handshake and returns results over a valid/ready handshake.
- Chains two ALU passes through the carry/borrow for 32-bit add/sub.
- Repeats single-bit shift/rotate opcodes to build a 0..15-bit shift.
- Sits between the datapath issue logic and the ALU instance. The ALU stays external.

Parameters:
- W, 16, ALU slice width. Request/response data width is 2*W.
- SHW, 4, shift-amount width. Maximum shift is 2**SHW-1.

Ports:
- clk  in  1  single clock; all state updates on the rising edge
- reset  in  1  synchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  sequencer can accept; high only in IDLE
- req_op  in  4  ALU opcode (same encoding as ALU OP)
- req_a  in  2W  operand A; only [W-1:0] used unless wide add/sub
- req_b  in  2W  operand B; same rule as req_a
- req_cin  in  1  carry-in for the first/only pass
- req_wide  in  1  1 = 32-bit add/sub; ignored for other opcodes
- req_shamt  in  SHW  repeat count for opcodes 1010..1111; ignored otherwise
- rsp_valid  out  1  result available
- rsp_ready  in  1  consumer takes result
- rsp_data  out  2W  result; upper W bits zero unless wide
- rsp_carry  out  1  final Cout (carry for add, borrow for sub); 0 for logic/shift ops
- alu_a  out  W  registered ALU operand A
- alu_b  out  W  registered ALU operand B
- alu_cin  out  1  registered ALU carry-in
- alu_op  out  4  registered ALU opcode
- alu_c  in  W  ALU result
- alu_cout  in  1  ALU carry/borrow out
- busy  out  1  high in any state other than IDLE

Behaviour:
- Reset (synchronous, active-high):
  - State goes to IDLE.
  - rsp_valid, rsp_data, rsp_carry, alu_a, alu_b, alu_cin, alu_op and busy are all 0. req_ready is 1.
  - Reset overrides every state. An in-flight operation is dropped and no response is produced.
- States: IDLE, LO, HI, SHIFT, RESP.
- IDLE:
  - Acceptance happens when req_valid && req_ready at an edge.
  - At acceptance, load alu_a=req_a[W-1:0], alu_b=req_b[W-1:0], alu_cin=req_cin, alu_op=req_op.
  - Latch req_a[2W-1:W], req_b[2W-1:W], req_wide, req_shamt.
  - Next state:
    - Shift/rotate opcode with shamt=0: RESP, with rsp_data = {0, req_a[W-1:0]} and rsp_carry = 0. No ALU step is taken.
    - Shift/rotate opcode with shamt>0: SHIFT, with the remaining count set to shamt.
    - Any other opcode: LO.
- LO (one cycle): alu_c and alu_cout are sampled at the end of the cycle.
  - Wide add/sub (op 0000/0001 and req_wide=1): store the low result. Load alu_a/alu_b with the high halves, alu_cin=alu_cout, same op. Go to HI.
  - Otherwise: rsp_data = {0, alu_c}. rsp_carry = alu_cout for op 0000/0001, else 0. Go to RESP.
- HI (one cycle): rsp_data = {alu_c, low}, rsp_carry = alu_cout. Go to RESP.
- SHIFT (one cycle per bit):
  - Each cycle: alu_a <= alu_c and decrement the count.
  - When the count reaches 1 at the edge: rsp_data = {0, alu_c}, rsp_carry = 0, go to RESP.
- RESP:
  - rsp_valid=1. rsp_data and rsp_carry are held stable until rsp_ready.
  - On rsp_valid && rsp_ready: go to IDLE and clear rsp_valid.
  - req_ready rises the cycle after the handshake; there is no same-cycle turnaround.
- Latency from the acceptance edge T to rsp_valid high:
  - Narrow op: cycle T+2.
  - Wide add/sub: T+3.
  - Shift by n>0: T+1+n.
  - Shift by 0: T+1.
- ALU outputs change only at edges and remain stable for a full cycle before sampling.
- alu_a/b/cin/op hold their last values in IDLE/RESP.
- Wide subtract semantics: high pass computes A_hi - (B_hi + borrow_lo). rsp_carry=1 means an unsigned underflow of the full 32-bit operation.

Decomposition:
- Shared include (alu_defs.vh) holds:
  - the 4-bit opcode constants (ADD, SUB, PASS, NAND, NOR, XNOR, NOT, AND, OR, XOR, LSR, ASR, ROR, LSL, ASL, ROL);
  - an is_shift helper (op[3:1] >= 3'b101 with op >= 4'b1010);
  - the state encoding.
- No sub-module. The ALU is instantiated alongside this block in the testbench and datapath.

Test Plan:
- Narrow add: op=0000, a=0x0001, b=0xFFFF, cin=0, wide=0 -> rsp_data=0x00000000, rsp_carry=1, rsp_valid at T+2.
- Wide add: a=0x0000FFFF, b=0x00000001, cin=0, wide=1 -> rsp_data=0x00010000, carry=0, at T+3. Also check alu_cin=1 during HI.
- Wide sub: a=0, b=1, wide=1 -> rsp_data=0xFFFFFFFF, carry=1. Then a=0x00010000, b=1 -> 0x0000FFFF, carry=0.
- Rotate left: op=1111, a=0x1234, shamt=4 -> rsp_data=0x00002341, carry=0, at T+5. With shamt=0 -> 0x00001234 at T+1, and alu_op is never stepped.
- Backpressure: hold rsp_ready=0 for 5 cycles after rsp_valid -> data stable and req_ready=0 throughout. Assert rsp_ready -> req_ready=1 the next cycle, and a back-to-back request is accepted.
- Reset mid-operation: assert reset during SHIFT with shamt=15 -> next cycle IDLE, rsp_valid=0, alu_* all 0, and no response is ever emitted.
